control_word_unit: RTL
======================

Name: control_word_unit

Overview:
- Parametrised, synchronous successor to the 8253 control word register, aligned with the 8254 feature set.
- Decodes bus writes and reads at the timer's address space and holds one 6-bit control word per counter.
- Issues per-counter load, count-latch and status-latch strobes.
- Implements the 8254 read-back command.
- Tracks the LSB/MSB byte-sequencing flip-flops for both write and read access.
- Sits between the bus interface and the counter instances.

Parameters:
- NUM_COUNTERS, 3, number of counters served; legal range 1..3.
- RESET_CW, 6'b110000, control word loaded into every counter at reset: RW=11, mode 0, binary.

Ports:
- Clk  in  1  system clock; all state changes on rising edge.
- Reset  in  1  asynchronous, active-high; clears all state immediately.
- WrStrobe  in  1  one-cycle write request, sampled on Clk.
- RdStrobe  in  1  one-cycle read request, sampled on Clk.
- Addr  in  2  register address; 0..NUM_COUNTERS-1 = counter data, 3 = control.
- DataIn  in  8  write data.
- ControlWord  out  6*NUM_COUNTERS  packed control words; counter i occupies bits [6i+5:6i] as {RW[1:0],M[2:0],BCD}.
- CwLoaded  out  NUM_COUNTERS  one-cycle pulse: new control word written to counter i.
- CountWrite  out  NUM_COUNTERS  one-cycle pulse: data byte written to counter i.
- CounterLatch  out  NUM_COUNTERS  one-cycle pulse: latch count of counter i.
- StatusLatch  out  NUM_COUNTERS  one-cycle pulse: latch status of counter i.
- WriteByteSel  out  NUM_COUNTERS  byte the next write to counter i targets; 0=LSB, 1=MSB.
- ReadByteSel  out  NUM_COUNTERS  byte the next read from counter i returns; 0=LSB, 1=MSB.
- IllegalCmd  out  1  one-cycle pulse on a rejected access.

Behaviour:
- Reset values:
  - every ControlWord slice = RESET_CW;
  - all pulse outputs 0;
  - WriteByteSel = 0, ReadByteSel = 0;
  - IllegalCmd = 0.
- All outputs are registered. Effects appear in the cycle after the strobe edge (latency 1). Pulses last exactly one cycle.
- Control write (WrStrobe, Addr=3), with SC = DataIn[7:6]:
  - SC < NUM_COUNTERS and DataIn[5:4] != 00:
    - ControlWord[SC] <= DataIn[5:0];
    - pulse CwLoaded[SC];
    - clear WriteByteSel[SC] and ReadByteSel[SC]. This also aborts any half-finished two-byte sequence.
  - SC < NUM_COUNTERS and DataIn[5:4] = 00 (counter latch command):
    - ControlWord is unchanged;
    - pulse CounterLatch[SC].
  - SC = 3 (read-back):
    - DataIn[0] must be 0; otherwise pulse IllegalCmd and take no other action.
    - For each k < NUM_COUNTERS with DataIn[k+1] = 1: pulse CounterLatch[k] if DataIn[5] = 0, and pulse StatusLatch[k] if DataIn[4] = 0.
    - Select bits for k >= NUM_COUNTERS are ignored.
    - DataIn[5:4] = 11 is legal and produces no pulses.
  - NUM_COUNTERS <= SC < 3: pulse IllegalCmd only.
- Counter data write (WrStrobe, Addr=i < NUM_COUNTERS):
  - Pulse CountWrite[i]; WriteByteSel[i] at strobe time tells the counter which byte is being written.
  - If RW=11, toggle WriteByteSel[i].
  - If RW=01 or 10, WriteByteSel[i] holds 0 and 1 respectively, i.e. it is forced to RW[1].
- Counter data read (RdStrobe, Addr=i < NUM_COUNTERS):
  - If RW=11, toggle ReadByteSel[i].
  - If RW=01 or 10, ReadByteSel[i] is forced to RW[1].
- Read at Addr=3: no effect.
- Write or read at an address in NUM_COUNTERS..2: pulse IllegalCmd, no state change.
- WrStrobe and RdStrobe in the same cycle: the write is executed, the read is discarded, and IllegalCmd pulses.
- Back-to-back strobes on consecutive cycles are each processed fully. There is no busy period.
- Reset asserted mid-sequence: all state clears asynchronously. A pulse that was in flight is dropped.

Test Plan:
- Reset, then idle 3 cycles -> ControlWord = {3{6'b110000}}, all sels 0, no pulses.
- Write 0x76 at Addr=3 -> ControlWord[1] = 6'b110110, CwLoaded = 3'b010 for one cycle. Then two writes at Addr=1 -> CountWrite[1] pulses twice; WriteByteSel[1] goes 0→1→0.
- After one LSB write to counter 1, write 0x76 again -> WriteByteSel[1] = 0. Write 0x40 -> CounterLatch = 3'b010, ControlWord[1] unchanged.
- Write read-back 0xCA (latch count+status for counters 0 and 2) -> CounterLatch = 3'b101 and StatusLatch = 3'b101 in the same cycle. Write 0xCB -> IllegalCmd pulse, no latch pulses.
- With NUM_COUNTERS=2: write 0x90 at Addr=3 and a data write at Addr=2 -> each gives an IllegalCmd pulse, state unchanged. Write 0xCE -> only bits [1:0] of the latch outputs pulse.
- WrStrobe and RdStrobe together at Addr=0 with RW=11 -> WriteByteSel[0] toggles, ReadByteSel[0] holds, IllegalCmd pulses. Reset asserted between two bytes -> sels = 0 immediately.

Source files
------------

// File: rtl/control_word_unit_if.sv
// Bus-side access port of the timer control word unit: one-cycle read/write
// strobes plus the register address and write data.
interface control_word_unit_if;
    logic       WrStrobe;
    logic       RdStrobe;
    logic [1:0] Addr;
    logic [7:0] DataIn;

    modport master (output WrStrobe, RdStrobe, Addr, DataIn);
    modport slave  (input  WrStrobe, RdStrobe, Addr, DataIn);
endinterface

// File: rtl/control_word_unit.sv
// 8254-style control word register bank: decodes control/data accesses, holds
// per-counter control words, byte-sequencing flops and latch/load strobes.
module control_word_unit #(
    parameter int unsigned NUM_COUNTERS = 3,
    parameter logic [5:0]  RESET_CW     = 6'b110000
) (
    input  logic                      Clk,
    input  logic                      Reset,
    control_word_unit_if.slave        bus,
    output logic [6*NUM_COUNTERS-1:0] ControlWord,
    output logic [NUM_COUNTERS-1:0]   CwLoaded,
    output logic [NUM_COUNTERS-1:0]   CountWrite,
    output logic [NUM_COUNTERS-1:0]   CounterLatch,
    output logic [NUM_COUNTERS-1:0]   StatusLatch,
    output logic [NUM_COUNTERS-1:0]   WriteByteSel,
    output logic [NUM_COUNTERS-1:0]   ReadByteSel,
    output logic                      IllegalCmd
);

    logic [NUM_COUNTERS-1:0][5:0] cw_q, cw_d;
    logic [NUM_COUNTERS-1:0]      cwl_q, cwl_d;
    logic [NUM_COUNTERS-1:0]      cwr_q, cwr_d;
    logic [NUM_COUNTERS-1:0]      cl_q, cl_d;
    logic [NUM_COUNTERS-1:0]      sl_q, sl_d;
    logic [NUM_COUNTERS-1:0]      wsel_q, wsel_d;
    logic [NUM_COUNTERS-1:0]      rsel_q, rsel_d;
    logic                         ill_q, ill_d;

    logic [1:0] sc;
    logic [2:0] rb_sel;
    logic       addr_valid;
    logic       sc_valid;

    assign sc         = bus.DataIn[7:6];
    assign rb_sel     = bus.DataIn[3:1];
    assign addr_valid = ({30'b0, bus.Addr} < NUM_COUNTERS);
    assign sc_valid   = ({30'b0, sc} < NUM_COUNTERS);

    always_comb begin
        cw_d   = cw_q;
        wsel_d = wsel_q;
        rsel_d = rsel_q;
        cwl_d  = '0;
        cwr_d  = '0;
        cl_d   = '0;
        sl_d   = '0;
        ill_d  = 1'b0;

        if (bus.WrStrobe) begin
            // A simultaneous read is dropped but still flagged.
            ill_d = bus.RdStrobe;
            if (bus.Addr == 2'd3) begin
                if (sc == 2'd3) begin
                    if (bus.DataIn[0]) begin
                        ill_d = 1'b1;
                    end else begin
                        for (int unsigned k = 0; k < NUM_COUNTERS; k++) begin
                            if (rb_sel[k]) begin
                                cl_d[k] = ~bus.DataIn[5];
                                sl_d[k] = ~bus.DataIn[4];
                            end
                        end
                    end
                end else if (!sc_valid) begin
                    ill_d = 1'b1;
                end else begin
                    for (int unsigned k = 0; k < NUM_COUNTERS; k++) begin
                        if (sc == 2'(k)) begin
                            if (bus.DataIn[5:4] != 2'b00) begin
                                cw_d[k]   = bus.DataIn[5:0];
                                cwl_d[k]  = 1'b1;
                                wsel_d[k] = 1'b0;
                                rsel_d[k] = 1'b0;
                            end else begin
                                cl_d[k] = 1'b1;
                            end
                        end
                    end
                end
            end else if (!addr_valid) begin
                ill_d = 1'b1;
            end else begin
                for (int unsigned k = 0; k < NUM_COUNTERS; k++) begin
                    if (bus.Addr == 2'(k)) begin
                        cwr_d[k]  = 1'b1;
                        wsel_d[k] = (cw_q[k][5:4] == 2'b11) ? ~wsel_q[k] : cw_q[k][5];
                    end
                end
            end
        end else if (bus.RdStrobe && (bus.Addr != 2'd3)) begin
            if (!addr_valid) begin
                ill_d = 1'b1;
            end else begin
                for (int unsigned k = 0; k < NUM_COUNTERS; k++) begin
                    if (bus.Addr == 2'(k)) begin
                        rsel_d[k] = (cw_q[k][5:4] == 2'b11) ? ~rsel_q[k] : cw_q[k][5];
                    end
                end
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cw_q   <= {NUM_COUNTERS{RESET_CW}};
            cwl_q  <= '0;
            cwr_q  <= '0;
            cl_q   <= '0;
            sl_q   <= '0;
            wsel_q <= '0;
            rsel_q <= '0;
            ill_q  <= 1'b0;
        end else begin
            cw_q   <= cw_d;
            cwl_q  <= cwl_d;
            cwr_q  <= cwr_d;
            cl_q   <= cl_d;
            sl_q   <= sl_d;
            wsel_q <= wsel_d;
            rsel_q <= rsel_d;
            ill_q  <= ill_d;
        end
    end

    assign ControlWord  = cw_q;
    assign CwLoaded     = cwl_q;
    assign CountWrite   = cwr_q;
    assign CounterLatch = cl_q;
    assign StatusLatch  = sl_q;
    assign WriteByteSel = wsel_q;
    assign ReadByteSel  = rsel_q;
    assign IllegalCmd   = ill_q;

endmodule
